// File: rtl/mem_slave_if.sv
// Request/ack bus between an interconnect master port and a memory slave.
// Master drives req/addr/cmd/wdata; slave returns a one-cycle ack plus rdata.
interface mem_slave_if #(
  parameter int N = 32
);
  logic         slave_req;
  logic [N-1:0] slave_addr;
  logic         slave_cmd;
  logic [N-1:0] slave_wdata;
  logic         slave_ack;
  logic [N-1:0] slave_rdata;

  modport master (
    output slave_req,
    output slave_addr,
    output slave_cmd,
    output slave_wdata,
    input  slave_ack,
    input  slave_rdata
  );

  modport slave (
    input  slave_req,
    input  slave_addr,
    input  slave_cmd,
    input  slave_wdata,
    output slave_ack,
    output slave_rdata
  );
endinterface

// File: rtl/mem_slave.sv
// Memory-backed req/ack responder with programmable read/write wait states.
// Ports: clk, rst (sync, active-low), bus (mem_slave_if.slave).
module mem_slave #(
  parameter int N           = 32,
  parameter int DEPTH_LOG2  = 4,
  parameter int READ_DELAY  = 4,
  parameter int WRITE_DELAY = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_slave_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  state_t state_q, state_d;

  logic [3:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  cmd_q;
  logic [N-1:0]          wdata_q;
  logic                  ack_q;
  logic [N-1:0]          rdata_q;
  logic [N-1:0]          mem [DEPTH];

  logic load, dec, fire;

  // Word index only; byte lane and upper bits alias.
  logic [DEPTH_LOG2-1:0] idx_in;
  assign idx_in = bus.slave_addr[DEPTH_LOG2+1:2];

  logic unused_addr;
  assign unused_addr = ^{bus.slave_addr[N-1:DEPTH_LOG2+2],
                         bus.slave_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.slave_req) begin
          state_d = WAIT;
          load    = 1'b1;
        end
      end
      WAIT: begin
        // Master gave up mid-wait: drop the access silently.
        if (!bus.slave_req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          fire    = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: begin
        // One ack per request even if req stays high.
        if (!bus.slave_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= fire;
      if (load) begin
        idx_q   <= idx_in;
        cmd_q   <= bus.slave_cmd;
        wdata_q <= bus.slave_wdata;
        cnt_q   <= bus.slave_cmd ? 4'(WRITE_DELAY - 1)
                                 : 4'(READ_DELAY - 1);
      end else if (dec) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (fire && !cmd_q) rdata_q <= mem[idx_q];
    end
  end

  // Array is not reset; a reset edge still blocks the commit.
  always_ff @(posedge clk) begin
    if (rst && fire && cmd_q) mem[idx_q] <= wdata_q;
  end

  assign bus.slave_ack   = ack_q;
  assign bus.slave_rdata = rdata_q;

endmodule

// File: tb/tb_mem_slave.sv
// Directed bench for mem_slave: latency, aliasing, hold, abort and reset.
// Drives on negedge, samples 1ns after posedge.
module tb_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_slave_if #(.N(32)) bus ();

  mem_slave #(
    .N(32), .DEPTH_LOG2(4),
    .READ_DELAY(4), .WRITE_DELAY(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns the latency (posedges from capture edge inclusive) and rdata
  // seen with ack; checks ack is low one cycle later.
  task automatic txn(input logic c,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input bit hold,
                     input string tag,
                     output logic [31:0] rd);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    rd   = 'x;
    @(negedge clk);
    bus.slave_req   = 1'b1;
    bus.slave_cmd   = c;
    bus.slave_addr  = a;
    bus.slave_wdata = d;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.slave_ack) begin
        seen = 1;
        rd   = bus.slave_rdata;
      end
    end
    chk({tag, "_lat"}, n, 5);
    @(posedge clk); #1;
    chk({tag, "_ack_lo"}, {31'd0, bus.slave_ack}, 32'd0);
    if (!hold) begin
      @(negedge clk);
      bus.slave_req = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input string tag);
    logic [31:0] rd;
    txn(1'b1, a, d, 1'b0, tag, rd);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp,
                        input string tag);
    logic [31:0] rd;
    txn(1'b0, a, 32'd0, 1'b0, tag, rd);
    chk({tag, "_data"}, rd, exp);
  endtask

  initial begin
    int          acks;
    logic [31:0] rd;
    bus.slave_req   = 1'b0;
    bus.slave_cmd   = 1'b0;
    bus.slave_addr  = '0;
    bus.slave_wdata = '0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ack",   {31'd0, bus.slave_ack}, 32'd0);
    chk("rst_rdata", bus.slave_rdata, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'd0);

    wr(32'h4, 32'h1111_1111, "w4");
    rd_chk(32'h4, 32'h1111_1111, "r4");

    wr(32'h44, 32'h2222_2222, "w44");
    rd_chk(32'h4, 32'h2222_2222, "r4_alias");

    wr(32'h8, 32'hAAAA_AAAA, "w8");
    wr(32'hC, 32'hCCCC_CCCC, "wc");
    wr(32'h10, 32'h1010_1010, "w10");
    rd_chk(32'h8, 32'hAAAA_AAAA, "r8");
    wr(32'h18, 32'h5555_5555, "w18");
    chk("rdata_hold", bus.slave_rdata, 32'hAAAA_AAAA);
    rd_chk(32'h1B, 32'h5555_5555, "r18_lane");

    txn(1'b0, 32'h4, 32'd0, 1'b1, "held", rd);
    chk("held_data", rd, 32'h2222_2222);
    acks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.slave_ack) acks++;
    end
    chk("held_acks", acks, 0);
    chk("held_state", 32'(dut.state_q), 32'd3);
    @(negedge clk);
    bus.slave_req = 1'b0;
    @(posedge clk); #1;
    chk("held_idle", 32'(dut.state_q), 32'd0);

    // Reset lands on edge k+2 of a write.
    acks = 0;
    @(negedge clk);
    bus.slave_req   = 1'b1;
    bus.slave_cmd   = 1'b1;
    bus.slave_addr  = 32'hC;
    bus.slave_wdata = 32'h3333_3333;
    @(posedge clk); #1;
    if (bus.slave_ack) acks++;
    @(posedge clk); #1;
    if (bus.slave_ack) acks++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.slave_ack) acks++;
    end
    @(negedge clk);
    bus.slave_req = 1'b0;
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.slave_ack) acks++;
    end
    chk("rstmid_acks", acks, 0);
    chk("rstmid_rdata", bus.slave_rdata, 32'h0);
    rd_chk(32'hC, 32'hCCCC_CCCC, "rstmid_rc");

    // Req dropped before edge k+2 of a write.
    acks = 0;
    @(negedge clk);
    bus.slave_req   = 1'b1;
    bus.slave_cmd   = 1'b1;
    bus.slave_addr  = 32'h10;
    bus.slave_wdata = 32'h4444_4444;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.slave_ack) acks++;
    end
    @(negedge clk);
    bus.slave_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", 32'(dut.state_q), 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.slave_ack) acks++;
    end
    chk("abort_acks", acks, 0);
    chk("abort_rdata", bus.slave_rdata, 32'hCCCC_CCCC);
    rd_chk(32'h10, 32'h1010_1010, "abort_r10");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
